// File: rtl/pconv_sched_c6_pkg.sv
// ---------------------------------------------------------------------------
// pconv_pkg
// Shared definitions for the partial-convolution layer sequencers:
//   state_t  - sequencer state encoding (IDLE, ISSUE, DRAIN, DONE)
//   LANES    - number of input-channel lanes in the pconv unit
//   clog2    - ceiling log2 with a floor of 1, used for port widths
// ---------------------------------------------------------------------------
package pconv_pkg;

   localparam int LANES = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Ceiling log2; never returns less than 1 so a degenerate count still
   // yields a legal one-bit bus.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((32'sd1 <<< result) < value) begin
         result = result + 1;
      end
      if (result < 1) begin
         result = 1;
      end else begin
         result = result;
      end
      return result;
   endfunction

endpackage

// File: rtl/pconv_sched_c6_addr_cnt.sv
// ---------------------------------------------------------------------------
// pconv_addr_cnt
// Two-level wrap counter walking (output channel, pixel) pairs. The pixel
// index is the fast digit; the channel advances when the pixel wraps.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clr         synchronous clear to (0,0); wins over en
//   en          advance one position
//   pix         current pixel index (registered)
//   oc          current output-channel index (registered)
//   last        high while the counter sits on the final pair
// ---------------------------------------------------------------------------
module pconv_addr_cnt #(
   parameter int PIX    = 784,
   parameter int OUT_CH = 8,
   parameter int PA_W   = 10,
   parameter int CA_W   = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            en,
   output logic [PA_W-1:0] pix,
   output logic [CA_W-1:0] oc,
   output logic            last
);

   localparam logic [PA_W-1:0] PIX_MAX = PA_W'(PIX - 1);
   localparam logic [CA_W-1:0] OC_MAX  = CA_W'(OUT_CH - 1);

   logic [PA_W-1:0] pix_r;
   logic [CA_W-1:0] oc_r;

   // Pixel/channel position register with wrap of both digits at the end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pix_r <= '0;
         oc_r  <= '0;
      end else if (clr) begin
         pix_r <= '0;
         oc_r  <= '0;
      end else if (en) begin
         if (pix_r == PIX_MAX) begin
            pix_r <= '0;
            if (oc_r == OC_MAX) begin
               oc_r <= '0;
            end else begin
               oc_r <= oc_r + CA_W'(1);
            end
         end else begin
            pix_r <= pix_r + PA_W'(1);
            oc_r  <= oc_r;
         end
      end else begin
         pix_r <= pix_r;
         oc_r  <= oc_r;
      end
   end

   assign pix  = pix_r;
   assign oc   = oc_r;
   assign last = (pix_r == PIX_MAX) && (oc_r == OC_MAX);

endmodule

// File: rtl/pconv_sched_c6.sv
// ---------------------------------------------------------------------------
// pconv_sched_c6
// Sequencer for one pointwise layer on the six-lane pconv unit. Issues one
// feature/coefficient read per cycle for every (oc, pix) pair, flags the
// returning RAM data to the unit with input_vld, and writes each result the
// unit hands back to address oc*PIX + pix, counting returns rather than
// assuming a pipeline latency.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, abort        layer request (idle only) / return to idle
//   busy, done          run in progress / one-cycle completion pulse
//   feat_rd_en/addr     feature RAM read, pixel index
//   coef_rd_en/addr     weight/bias/shift ROM read, output-channel index
//   ce, input_vld       pconv unit enable and input valid
//   conv_vld            pconv unit result valid
//   res_wr_en/addr      result RAM write, linear address
// All outputs are registered and reset to 0.
// ---------------------------------------------------------------------------
module pconv_sched_c6
   import pconv_pkg::*;
#(
   parameter int N       = 16,
   parameter int IN_SIZE = 28,
   parameter int OUT_CH  = 8,
   localparam int PIX    = IN_SIZE * IN_SIZE,
   localparam int PA_W   = clog2(PIX),
   localparam int CA_W   = clog2(OUT_CH),
   localparam int RA_W   = clog2(PIX * OUT_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   output logic            busy,
   output logic            done,
   output logic            feat_rd_en,
   output logic [PA_W-1:0] feat_addr,
   output logic            coef_rd_en,
   output logic [CA_W-1:0] coef_addr,
   output logic            ce,
   output logic            input_vld,
   input  logic            conv_vld,
   output logic            res_wr_en,
   output logic [RA_W-1:0] res_wr_addr
);

   localparam logic [RA_W:0] RES_TOTAL = (RA_W + 1)'(PIX * OUT_CH);

   state_t          state_r;
   state_t          state_next_s;
   logic            busy_r;
   logic            done_r;
   logic            rd_en_r;
   logic            input_vld_r;
   logic            res_wr_en_r;
   logic [RA_W-1:0] wr_addr_r;
   logic [RA_W:0]   wr_cnt_r;
   logic [RA_W:0]   wr_cnt_next_s;
   logic            wr_done_s;
   logic            accept_s;
   logic            issue_s;
   logic            last_s;
   logic [PA_W-1:0] pix_s;
   logic [CA_W-1:0] oc_s;

   assign issue_s       = (state_r == ST_ISSUE);
   assign accept_s      = (state_r == ST_IDLE) && start && !abort;
   // The write being presented this cycle counts toward completion, so done
   // lands exactly one cycle after the final write strobe.
   assign wr_cnt_next_s = wr_cnt_r + {{RA_W{1'b0}}, res_wr_en_r};
   assign wr_done_s     = (wr_cnt_next_s == RES_TOTAL);

   pconv_addr_cnt #(
      .PIX    (PIX),
      .OUT_CH (OUT_CH),
      .PA_W   (PA_W),
      .CA_W   (CA_W)
   ) u_addr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept_s | abort),
      .en    (issue_s),
      .pix   (pix_s),
      .oc    (oc_s),
      .last  (last_s)
   );

   // Next-state decode; abort overrides every transition, start included.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_next_s = ST_ISSUE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (last_s) begin
               state_next_s = ST_DRAIN;
            end else begin
               state_next_s = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (wr_done_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
      if (abort) begin
         state_next_s = ST_IDLE;
      end else begin
         state_next_s = state_next_s;
      end
   end

   // State, registered strobes and the result address/count counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         rd_en_r     <= 1'b0;
         input_vld_r <= 1'b0;
         res_wr_en_r <= 1'b0;
         wr_addr_r   <= '0;
         wr_cnt_r    <= '0;
      end else begin
         state_r     <= state_next_s;
         busy_r      <= (state_next_s != ST_IDLE);
         done_r      <= (state_next_s == ST_DONE);
         rd_en_r     <= (state_next_s == ST_ISSUE);
         // RAM data arrives one cycle after the read, so the valid follows.
         input_vld_r <= rd_en_r && !abort;
         // Returns outside a run (idle, or in flight after abort) are dropped.
         res_wr_en_r <= conv_vld && busy_r && !abort;
         if (accept_s || abort) begin
            wr_addr_r <= '0;
            wr_cnt_r  <= '0;
         end else begin
            wr_cnt_r <= wr_cnt_next_s;
            if (res_wr_en_r) begin
               wr_addr_r <= wr_addr_r + RA_W'(1);
            end else begin
               wr_addr_r <= wr_addr_r;
            end
         end
      end
   end

   assign busy        = busy_r;
   assign ce          = busy_r;
   assign done        = done_r;
   assign feat_rd_en  = rd_en_r;
   assign coef_rd_en  = rd_en_r;
   assign feat_addr   = pix_s;
   assign coef_addr   = oc_s;
   assign input_vld   = input_vld_r;
   assign res_wr_en   = res_wr_en_r;
   assign res_wr_addr = wr_addr_r;

endmodule
